// File: rtl/sevenseg_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment scan driver.
// Frame-synchronous snapshot, ghosting guard, leading-zero blanking.
module sevenseg_scan_driver #(
   parameter int DIGIT_CYCLES = 100_000,
   parameter int GHOST_CYCLES = 1_000,
   parameter int DP_DIGIT     = 2,
   parameter int BLANK_LEAD   = 1
) (
   input  logic        clk100Mhz,
   input  logic        rst,
   input  logic [15:0] display_bcd,
   input  logic        dp,
   input  logic        blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp_n,
   output logic        frame_done,
   output logic        bcd_err
);

   localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST  = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] GHOST = CW'(GHOST_CYCLES);
   localparam logic [1:0]    DPI   = 2'(DP_DIGIT);

   typedef enum logic {GUARD, ON} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    idx;
   logic [15:0]   snapshot, src_bcd;
   logic          dp_snap, src_dp;
   logic          capture, err_in;
   logic [3:0]    nib;
   logic [3:0]    lz;
   logic          lead_blank;
   logic [3:0]    an_d;
   logic [6:0]    seg_d;
   logic          dp_n_d;

   function automatic logic [6:0] enc(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign capture = (idx == 2'd0) && (cnt == '0);
   assign cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);

   // On the capture edge the slot renders from the value being latched
   assign src_bcd = capture ? display_bcd : snapshot;
   assign src_dp  = capture ? dp : dp_snap;

   assign err_in = (display_bcd[3:0]   > 4'd9) ||
                   (display_bcd[7:4]   > 4'd9) ||
                   (display_bcd[11:8]  > 4'd9) ||
                   (display_bcd[15:12] > 4'd9);

   always_ff @(posedge clk100Mhz) begin
      if (rst) begin
         cnt <= '0;
         idx <= 2'd0;
      end else begin
         cnt <= cnt_nxt;
         if (cnt == LAST)
            idx <= idx + 2'd1;
      end
   end

   always_ff @(posedge clk100Mhz) begin
      if (rst) begin
         snapshot   <= 16'h0000;
         dp_snap    <= 1'b0;
         bcd_err    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= capture;
         if (capture) begin
            snapshot <= display_bcd;
            dp_snap  <= dp;
            bcd_err  <= err_in;
         end
      end
   end

   always_ff @(posedge clk100Mhz) begin
      if (rst)
         state <= (GHOST == '0) ? ON : GUARD;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = (cnt_nxt < GHOST) ? GUARD : ON;
   end

   // lz[i]: nibbles i..3 are all zero
   assign lz[3] = (src_bcd[15:12] == 4'd0);
   assign lz[2] = lz[3] && (src_bcd[11:8] == 4'd0);
   assign lz[1] = lz[2] && (src_bcd[7:4] == 4'd0);
   assign lz[0] = lz[1] && (src_bcd[3:0] == 4'd0);

   assign nib = src_bcd[{idx, 2'b00} +: 4];
   assign lead_blank = (BLANK_LEAD != 0) && (idx != 2'd0) && lz[idx] &&
                       !(src_dp && (idx <= DPI));

   always_comb begin
      an_d   = 4'hF;
      seg_d  = 7'h7F;
      dp_n_d = 1'b1;
      if (state == ON && !blank && !lead_blank) begin
         an_d   = ~(4'b0001 << idx);
         seg_d  = enc(nib);
         dp_n_d = ~(src_dp && (idx == DPI));
      end
   end

   always_ff @(posedge clk100Mhz) begin
      if (rst) begin
         an   <= 4'hF;
         seg  <= 7'h7F;
         dp_n <= 1'b1;
      end else begin
         an   <= an_d;
         seg  <= seg_d;
         dp_n <= dp_n_d;
      end
   end

endmodule
